// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS receive checker: polynomial selection,
// per-mode order/tap constants and the acquisition state encoding.
package prbs_pkg;

  localparam int unsigned HistW = 31;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'd0,
    MODE_PRBS15 = 2'd1,
    MODE_PRBS23 = 2'd2,
    MODE_PRBS31 = 2'd3
  } prbs_mode_e;

  localparam logic [4:0] Order7  = 5'd7;
  localparam logic [4:0] Tap7    = 5'd6;
  localparam logic [4:0] Order15 = 5'd15;
  localparam logic [4:0] Tap15   = 5'd14;
  localparam logic [4:0] Order23 = 5'd23;
  localparam logic [4:0] Tap23   = 5'd18;
  localparam logic [4:0] Order31 = 5'd31;
  localparam logic [4:0] Tap31   = 5'd28;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_e;

  typedef struct packed {
    logic [4:0] order;
    logic [4:0] tap;
  } poly_t;

  function automatic poly_t poly_of(input logic [1:0] mode);
    poly_t p;
    case (prbs_mode_e'(mode))
      MODE_PRBS7:  p = '{order: Order7,  tap: Tap7};
      MODE_PRBS15: p = '{order: Order15, tap: Tap15};
      MODE_PRBS23: p = '{order: Order23, tap: Tap23};
      default:     p = '{order: Order31, tap: Tap31};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/prbs_step.sv
// Combinational PRBS advance over one word. With use_data set the received
// bits feed the history (self-synchronous); otherwise predicted bits do.
module prbs_step
  import prbs_pkg::*;
#(
  parameter int unsigned BusWidth = 8
) (
  input  logic [HistW-1:0]    hist,
  input  logic [1:0]          mode,
  input  logic [BusWidth-1:0] data,
  input  logic                use_data,
  output logic [HistW-1:0]    hist_next,
  output logic [BusWidth-1:0] pred,
  output logic [BusWidth-1:0] mismatch
);

  poly_t            poly;
  logic [4:0]       o_idx;
  logic [4:0]       t_idx;
  logic [HistW-1:0] h;
  logic             bit_p;

  assign poly  = poly_of(mode);
  assign o_idx = poly.order - 5'd1;
  assign t_idx = poly.tap - 5'd1;

  // Word MSB is earliest in time, so it is processed first.
  always_comb begin
    h        = hist;
    bit_p    = 1'b0;
    pred     = '0;
    mismatch = '0;
    for (int unsigned k = 0; k < BusWidth; k++) begin
      bit_p                    = h[o_idx] ^ h[t_idx];
      pred[BusWidth-1-k]       = bit_p;
      mismatch[BusWidth-1-k]   = bit_p ^ data[BusWidth-1-k];
      h = {h[HistW-2:0], (use_data ? data[BusWidth-1-k] : bit_p)};
    end
    hist_next = h;
  end

endmodule

// File: rtl/prbs_lock_checker.sv
// PRBS-7/15/23/31 receive checker: fills and self-synchronises on received
// data, then flywheels on a local generator and counts bit errors.
module prbs_lock_checker
  import prbs_pkg::*;
#(
  parameter int unsigned BusWidth    = 8,
  parameter int unsigned ErrCntWidth = 16,
  parameter int unsigned LockCount   = 4,
  parameter int unsigned LossCount   = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   InValid,
  input  logic [BusWidth-1:0]    InData,
  input  logic [1:0]             Mode,
  input  logic                   ClrCnt,
  output logic                   Locked,
  output logic                   WordErr,
  output logic [ErrCntWidth-1:0] ErrBits,
  output logic [1:0]             State
);

  localparam int unsigned FillW = 7;
  localparam int unsigned GoodW = $clog2(LockCount + 1);
  localparam int unsigned BadW  = $clog2(LossCount + 1);
  localparam int unsigned PopW  = $clog2(BusWidth + 1);
  localparam int unsigned SumW  = ((ErrCntWidth > PopW) ? ErrCntWidth : PopW) + 1;
  localparam logic [ErrCntWidth-1:0] ErrMax = '1;

  lock_state_e            state_q, state_d;
  logic [1:0]             mode_q;
  logic [HistW-1:0]       hist_q, hist_d;
  logic [HistW-1:0]       gen_q, gen_d;
  logic [FillW-1:0]       fill_q, fill_d;
  logic [GoodW-1:0]       good_q, good_d;
  logic [BadW-1:0]        bad_q, bad_d;
  logic [ErrCntWidth-1:0] err_q, err_d;
  logic                   word_err_q, word_err_d;
  logic                   locked_q;

  logic [HistW-1:0]       rx_hist, gen_hist;
  logic [BusWidth-1:0]    rx_pred, rx_mis, gen_pred, gen_mis;
  poly_t                  cur_poly;
  logic [PopW-1:0]        pop;
  logic [SumW-1:0]        sum;
  logic [ErrCntWidth-1:0] err_sat;
  logic                   unused_bits;

  prbs_step #(.BusWidth(BusWidth)) u_rx_step (
    .hist      (hist_q),
    .mode      (mode_q),
    .data      (InData),
    .use_data  (1'b1),
    .hist_next (rx_hist),
    .pred      (rx_pred),
    .mismatch  (rx_mis)
  );

  prbs_step #(.BusWidth(BusWidth)) u_gen_step (
    .hist      (gen_q),
    .mode      (mode_q),
    .data      (InData),
    .use_data  (1'b0),
    .hist_next (gen_hist),
    .pred      (gen_pred),
    .mismatch  (gen_mis)
  );

  assign cur_poly    = poly_of(mode_q);
  assign unused_bits = ^{rx_pred, gen_pred, cur_poly.tap};

  always_comb begin
    pop = '0;
    for (int unsigned k = 0; k < BusWidth; k++) begin
      pop = pop + PopW'(gen_mis[k]);
    end
    sum     = SumW'(err_q) + SumW'(pop);
    err_sat = (sum > SumW'(ErrMax)) ? ErrMax : sum[ErrCntWidth-1:0];
  end

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    gen_d      = gen_q;
    fill_d     = fill_q;
    good_d     = good_q;
    bad_d      = bad_q;
    err_d      = err_q;
    word_err_d = 1'b0;

    if (InValid) begin
      case (state_q)
        ST_FILL: begin
          hist_d = rx_hist;
          fill_d = fill_q + FillW'(BusWidth);
          if (fill_d >= FillW'(cur_poly.order)) state_d = ST_HUNT;
        end
        ST_HUNT: begin
          hist_d = rx_hist;
          if (rx_mis == '0) begin
            good_d = good_q + GoodW'(1);
            if (good_d == GoodW'(LockCount)) begin
              state_d = ST_LOCKED;
              gen_d   = rx_hist;
            end
          end else begin
            good_d = '0;
          end
        end
        ST_LOCKED: begin
          gen_d      = gen_hist;
          err_d      = err_sat;
          word_err_d = |gen_mis;
          if (|gen_mis) begin
            bad_d = bad_q + BadW'(1);
            if (bad_d == BadW'(LossCount)) begin
              state_d = ST_FILL;
              fill_d  = '0;
              good_d  = '0;
              bad_d   = '0;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end

    if (ClrCnt) err_d = '0;

    // A mode change overrides whatever the word did to the state, but any
    // error accumulation from that word above is kept.
    if (Mode != mode_q) begin
      state_d = ST_FILL;
      fill_d  = '0;
      good_d  = '0;
      bad_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_FILL;
      mode_q     <= '0;
      hist_q     <= '0;
      gen_q      <= '0;
      fill_q     <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      err_q      <= '0;
      word_err_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= Mode;
      hist_q     <= hist_d;
      gen_q      <= gen_d;
      fill_q     <= fill_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
      word_err_q <= word_err_d;
      locked_q   <= (state_d == ST_LOCKED);
    end
  end

  assign Locked  = locked_q;
  assign WordErr = word_err_q;
  assign ErrBits = err_q;
  assign State   = state_q;

endmodule

// File: tb/tb_prbs_lock_checker.sv
// Directed bench for prbs_lock_checker: acquisition, error injection, loss,
// mode switch, counter saturation/clear and asynchronous reset.
module tb_prbs_lock_checker;

  logic       CLK = 1'b0;
  logic       RST;
  logic       InValid;
  logic [7:0] InData;
  logic [1:0] Mode;
  logic       ClrCnt;

  logic        locked, word_err;
  logic [15:0] err_bits;
  logic [1:0]  state;
  logic        locked4, word_err4;
  logic [3:0]  err_bits4;
  logic [1:0]  state4;

  int checks = 0;
  int errors = 0;

  logic [30:0] lfsr;
  int unsigned ord, tap;

  always #5 CLK = ~CLK;

  prbs_lock_checker #(.BusWidth(8), .ErrCntWidth(16), .LockCount(4), .LossCount(4)) dut (
    .CLK(CLK), .RST(RST), .InValid(InValid), .InData(InData), .Mode(Mode),
    .ClrCnt(ClrCnt), .Locked(locked), .WordErr(word_err), .ErrBits(err_bits),
    .State(state)
  );

  prbs_lock_checker #(.BusWidth(8), .ErrCntWidth(4), .LockCount(4), .LossCount(4)) dut4 (
    .CLK(CLK), .RST(RST), .InValid(InValid), .InData(InData), .Mode(Mode),
    .ClrCnt(ClrCnt), .Locked(locked4), .WordErr(word_err4), .ErrBits(err_bits4),
    .State(state4)
  );

  task automatic seed(input int unsigned n, input int unsigned t, input logic [30:0] s);
    ord  = n;
    tap  = t;
    lfsr = s;
  endtask

  task automatic next_word(output logic [7:0] w);
    logic b;
    w = '0;
    for (int i = 7; i >= 0; i--) begin
      b    = lfsr[ord-1] ^ lfsr[tap-1];
      lfsr = {lfsr[29:0], b};
      w[i] = b;
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    InValid = v;
    InData  = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    RST = 1'b0; InValid = 1'b0; ClrCnt = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(2);
  endtask

  task automatic test_reset();
    RST = 1'b0; InValid = 1'b0; ClrCnt = 1'b0; InData = '0; Mode = 2'd1;
    @(posedge CLK);
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b want=0", locked); end
    checks++; if (word_err !== 1'b0) begin errors++; $display("FAIL reset_worderr got=%0b want=0", word_err); end
    checks++; if (err_bits !== 16'd0) begin errors++; $display("FAIL reset_errbits got=%0d want=0", err_bits); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
    RST = 1'b1;
    idle(2);
  endtask

  task automatic test_acquire(input string tag);
    logic [7:0] w;
    seed(15, 14, 31'h7FFF);
    for (int i = 1; i <= 6; i++) begin
      next_word(w);
      cycle(1'b1, w);
      checks++; if (word_err !== 1'b0) begin errors++; $display("FAIL %s_worderr w%0d got=%0b want=0", tag, i, word_err); end
      if (i == 1) begin
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL %s_state_w1 got=%0d want=0", tag, state); end
      end
      if (i == 2) begin
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL %s_state_w2 got=%0d want=1", tag, state); end
      end
      if (i == 5) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL %s_locked_w5 got=%0b want=0", tag, locked); end
      end
      if (i == 6) begin
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL %s_locked_w6 got=%0b want=1", tag, locked); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL %s_state_w6 got=%0d want=2", tag, state); end
      end
    end
    checks++; if (err_bits !== 16'd0) begin errors++; $display("FAIL %s_errbits got=%0d want=0", tag, err_bits); end
  endtask

  task automatic test_single_error();
    logic [7:0] w;
    next_word(w);
    cycle(1'b1, w ^ 8'h10);
    checks++; if (word_err !== 1'b1) begin errors++; $display("FAIL single_worderr got=%0b want=1", word_err); end
    checks++; if (err_bits !== 16'd1) begin errors++; $display("FAIL single_errbits got=%0d want=1", err_bits); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got=%0b want=1", locked); end
    next_word(w);
    cycle(1'b1, w);
    checks++; if (word_err !== 1'b0) begin errors++; $display("FAIL single_pulse_end got=%0b want=0", word_err); end
  endtask

  task automatic test_gaps();
    logic [7:0] w;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        cycle(1'b0, 8'($urandom));
        checks++; if (word_err !== 1'b0) begin errors++; $display("FAIL gap_worderr i%0d got=%0b want=0", i, word_err); end
      end
      next_word(w);
      cycle(1'b1, w);
      checks++; if (word_err !== 1'b0) begin errors++; $display("FAIL gap_word i%0d got=%0b want=0", i, word_err); end
    end
    checks++; if (err_bits !== 16'd1) begin errors++; $display("FAIL gap_errbits got=%0d want=1", err_bits); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gap_locked got=%0b want=1", locked); end
  endtask

  task automatic test_loss();
    logic [7:0] w;
    ClrCnt = 1'b1;
    cycle(1'b0, 8'h00);
    ClrCnt = 1'b0;
    checks++; if (err_bits !== 16'd0) begin errors++; $display("FAIL loss_clear got=%0d want=0", err_bits); end
    for (int i = 1; i <= 4; i++) begin
      next_word(w);
      cycle(1'b1, w ^ 8'hFF);
      checks++; if (word_err !== 1'b1) begin errors++; $display("FAIL loss_worderr w%0d got=%0b want=1", i, word_err); end
      if (i < 4) begin
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_locked w%0d got=%0b want=1", i, locked); end
      end else begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_unlocked got=%0b want=0", locked); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL loss_state got=%0d want=0", state); end
        checks++; if (err_bits !== 16'd32) begin errors++; $display("FAIL loss_errbits got=%0d want=32", err_bits); end
      end
    end
    for (int i = 1; i <= 6; i++) begin
      next_word(w);
      cycle(1'b1, w);
      if (i == 5) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early got=%0b want=0", locked); end
      end
      if (i == 6) begin
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock got=%0b want=1", locked); end
      end
    end
  endtask

  task automatic test_mode_change();
    logic [7:0] w;
    Mode = 2'd0;
    cycle(1'b0, 8'h00);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL mode_state got=%0d want=0", state); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mode_locked got=%0b want=0", locked); end
    checks++; if (err_bits !== 16'd32) begin errors++; $display("FAIL mode_errbits got=%0d want=32", err_bits); end
    seed(7, 6, 31'h7F);
    for (int i = 1; i <= 5; i++) begin
      next_word(w);
      cycle(1'b1, w);
      if (i == 1) begin
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL mode_hunt got=%0d want=1", state); end
      end
      if (i == 4) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mode_early got=%0b want=0", locked); end
      end
      if (i == 5) begin
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mode_lock got=%0b want=1", locked); end
      end
    end
    checks++; if (err_bits !== 16'd32) begin errors++; $display("FAIL mode_errbits_end got=%0d want=32", err_bits); end
  endtask

  task automatic test_saturation();
    logic [7:0] w;
    Mode = 2'd1;
    do_reset();
    test_acquire("sat_acq");
    checks++; if (locked4 !== 1'b1) begin errors++; $display("FAIL sat_locked4 got=%0b want=1", locked4); end
    for (int i = 1; i <= 3; i++) begin
      next_word(w);
      cycle(1'b1, w ^ 8'hFF);
      if (i == 1) begin
        checks++; if (err_bits4 !== 4'd8) begin errors++; $display("FAIL sat_first got=%0d want=8", err_bits4); end
      end
    end
    checks++; if (err_bits4 !== 4'd15) begin errors++; $display("FAIL sat_errbits4 got=%0d want=15", err_bits4); end
    checks++; if (err_bits !== 16'd24) begin errors++; $display("FAIL sat_errbits16 got=%0d want=24", err_bits); end
    checks++; if (locked4 !== 1'b1) begin errors++; $display("FAIL sat_still_locked got=%0b want=1", locked4); end
    next_word(w);
    cycle(1'b1, w);
    ClrCnt = 1'b1;
    next_word(w);
    cycle(1'b1, w ^ 8'h01);
    ClrCnt = 1'b0;
    checks++; if (err_bits4 !== 4'd0) begin errors++; $display("FAIL clr_errbits4 got=%0d want=0", err_bits4); end
    checks++; if (err_bits !== 16'd0) begin errors++; $display("FAIL clr_errbits16 got=%0d want=0", err_bits); end
    checks++; if (word_err4 !== 1'b1) begin errors++; $display("FAIL clr_worderr got=%0b want=1", word_err4); end
  endtask

  task automatic test_async_reset();
    logic [7:0] w;
    next_word(w);
    cycle(1'b1, w ^ 8'h03);
    InValid = 1'b0;
    checks++; if (err_bits !== 16'd2) begin errors++; $display("FAIL areset_pre got=%0d want=2", err_bits); end
    #3;
    RST = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL areset_locked got=%0b want=0", locked); end
    checks++; if (err_bits !== 16'd0) begin errors++; $display("FAIL areset_errbits got=%0d want=0", err_bits); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL areset_state got=%0d want=0", state); end
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    idle(1);
    test_acquire("reacq");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_acquire("acq");
    test_single_error();
    test_gaps();
    test_loss();
    test_mode_change();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
